// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// state encoding, opcodes, ALU op classes and datapath mux encodings.
package multicycle_pkg;

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_R     = 4'd8,
        WB_I     = 4'd9,
        WB_MEM   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        HALT     = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_SLT   = 3'b011
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // States that hold a memory request open until the memory acknowledges.
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Memory-wait watchdog: counts cycles spent waiting for an ack and flags
// expiry when the wait reaches TIMEOUT without an ack (TIMEOUT=0 disables).
module mem_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic wait_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Restart on every state entry, count unacknowledged wait cycles, saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i && !ack_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack arriving in the limit cycle wins over expiry.
    always_comb begin
        expired_o = (TIMEOUT != 0) && wait_i && !ack_i && (cnt_q == LIMIT);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath. Outputs are decoded
// from the state register plus opcode/zero/ack. Optional performance
// counters are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       alu_zero_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       halt_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt_o,
    output logic [31:0] retire_cnt_o
`endif
);

    state_e state_q;
    state_e state_d;
    logic   bus_err_q;
    logic   bus_err_d;
    logic   wd_expired;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_d != state_q),
        .wait_i    (is_mem_state(state_q)),
        .ack_i     (mem_ack_i),
        .expired_o (wd_expired)
    );

    // Next-state and per-state datapath controls, everything defaulted to 0.
    always_comb begin
        state_d      = state_q;
        bus_err_d    = bus_err_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                if (mem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end else if (wd_expired) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
                case (opcode_i)
                    OP_RTYPE:         state_d = EXEC_R;
                    OP_ADDI, OP_SLTI: state_d = EXEC_I;
                    OP_LW, OP_SW:     state_d = MEM_ADDR;
                    OP_BEQ:           state_d = BRANCH;
                    OP_J:             state_d = JUMP;
                    default:          state_d = HALT;
                endcase
            end
            EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_RTYPE;
                state_d     = WB_R;
            end
            WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_d     = FETCH;
            end
            EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d     = WB_I;
            end
            WB_I: begin
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_d     = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = (state_q == MEM_WR);
                if (mem_ack_i) begin
                    state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
                end else if (wd_expired) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_write_o  = alu_zero_i;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_o   = PC_SRC_JUMP;
                pc_write_o = 1'b1;
                state_d    = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // State and sticky bus-error registers; reset wins from any state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RESET;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Status outputs taken straight from the registers.
    always_comb begin
        halt_o    = (state_q == HALT);
        bus_err_o = bus_err_q;
        state_o   = state_q;
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] cyc_cnt_d;
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    // Count active cycles, and retirements as entries into FETCH after reset.
    always_comb begin
        cyc_cnt_d    = cyc_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if ((state_q != RESET) && (state_q != HALT)) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        if ((state_d == FETCH) && (state_q != FETCH) && (state_q != RESET)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            cyc_cnt_q    <= cyc_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cyc_cnt_o    = cyc_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// expected outputs, and a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halt;
        logic       bus_err;
    } out_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       alu_zero_i;
    logic       mem_ack_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o, halt_o, bus_err_o;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;
    out_t  exp_q[$];
    string tag_q[$];

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .alu_zero_i   (alu_zero_i),
        .mem_ack_i    (mem_ack_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .halt_o       (halt_o),
        .bus_err_o    (bus_err_o),
        .state_o      (state_o)
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    // Expected outputs for a given state and inputs, straight from the state table.
    function automatic out_t expOut(state_e s, logic [5:0] op, logic z, logic ack, logic berr);
        out_t e;
        e = '0;
        e.state   = s;
        e.bus_err = berr;
        case (s)
            FETCH: begin
                e.mem_req = 1'b1; e.alu_src_b = 2'd1;
                e.ir_write = ack; e.pc_write = ack;
            end
            DECODE:   e.alu_src_b = 2'd3;
            EXEC_R:   begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
            WB_R:     begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            EXEC_I: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                e.alu_op = (op == 6'h0A) ? 3'b011 : 3'b000;
            end
            WB_I:     e.reg_write = 1'b1;
            MEM_ADDR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            MEM_RD:   begin e.mem_req = 1'b1; e.iord = 1'b1; end
            MEM_WR:   begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; end
            WB_MEM:   begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b001;
                e.pc_src = 2'd1; e.pc_write = z;
            end
            JUMP:     begin e.pc_src = 2'd2; e.pc_write = 1'b1; end
            HALT:     e.halt = 1'b1;
            default:  ;
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs, record the expected response, advance a cycle.
    task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] op,
                                 input logic z, input logic ack, input state_e s,
                                 input logic berr);
        rst_i      = rst;
        opcode_i   = op;
        alu_zero_i = z;
        mem_ack_i  = ack;
        exp_q.push_back(expOut(s, op, z, ack, berr));
        tag_q.push_back(tag);
        @(posedge clk_i);
        #1;
    endtask

    // Compare the DUT's outputs against one scoreboard entry.
    task automatic checkOutput(input string tag, input out_t e);
        out_t a;
        a.state = state_o;       a.mem_req = mem_req_o;     a.mem_we = mem_we_o;
        a.iord = iord_o;         a.ir_write = ir_write_o;   a.pc_write = pc_write_o;
        a.pc_src = pc_src_o;     a.alu_src_a = alu_src_a_o; a.alu_src_b = alu_src_b_o;
        a.alu_op = alu_op_o;     a.reg_write = reg_write_o; a.reg_dst = reg_dst_o;
        a.mem_to_reg = mem_to_reg_o; a.halt = halt_o;       a.bus_err = bus_err_o;
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     tag, a.state, a, e.state, e);
        end
    endtask

    // Monitor: pop and check one expected entry each cycle, away from the clock edge.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            checkOutput(tag_q.pop_front(), exp_q.pop_front());
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed instruction sequences.
    initial begin
        rst_i = 1'b1; opcode_i = '0; alu_zero_i = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        applyStimulus("reset_hold", 1, 6'h00, 0, 0, RESET, 0);
        applyStimulus("reset_hold_ack", 1, 6'h00, 1, 1, RESET, 0);
        applyStimulus("reset_release", 0, 6'h00, 0, 0, RESET, 0);

        // addi, slti, add: 4 cycles each
        applyStimulus("addi_f", 0, 6'h08, 0, 1, FETCH, 0);
        applyStimulus("addi_d", 0, 6'h08, 0, 0, DECODE, 0);
        applyStimulus("addi_x", 0, 6'h08, 0, 0, EXEC_I, 0);
        applyStimulus("addi_wb", 0, 6'h08, 0, 0, WB_I, 0);
        applyStimulus("slti_f", 0, 6'h0A, 0, 1, FETCH, 0);
        applyStimulus("slti_d", 0, 6'h0A, 0, 0, DECODE, 0);
        applyStimulus("slti_x", 0, 6'h0A, 0, 0, EXEC_I, 0);
        applyStimulus("slti_wb", 0, 6'h0A, 0, 0, WB_I, 0);
        applyStimulus("add_f", 0, 6'h00, 0, 1, FETCH, 0);
        applyStimulus("add_d", 0, 6'h00, 0, 1, DECODE, 0);
        applyStimulus("add_x", 0, 6'h00, 0, 0, EXEC_R, 0);
        applyStimulus("add_wb", 0, 6'h00, 0, 0, WB_R, 0);
        // sw: 4, lw: 5
        applyStimulus("sw_f", 0, 6'h2B, 0, 1, FETCH, 0);
        applyStimulus("sw_d", 0, 6'h2B, 0, 0, DECODE, 0);
        applyStimulus("sw_a", 0, 6'h2B, 0, 0, MEM_ADDR, 0);
        applyStimulus("sw_m", 0, 6'h2B, 0, 1, MEM_WR, 0);
        applyStimulus("lw_f", 0, 6'h23, 0, 1, FETCH, 0);
        applyStimulus("lw_d", 0, 6'h23, 0, 0, DECODE, 0);
        applyStimulus("lw_a", 0, 6'h23, 0, 0, MEM_ADDR, 0);
        applyStimulus("lw_m", 0, 6'h23, 0, 1, MEM_RD, 0);
        applyStimulus("lw_wb", 0, 6'h23, 0, 0, WB_MEM, 0);
        // beq taken and j: 3 each
        applyStimulus("beq_f", 0, 6'h04, 1, 1, FETCH, 0);
        applyStimulus("beq_d", 0, 6'h04, 1, 0, DECODE, 0);
        applyStimulus("beq_taken", 0, 6'h04, 1, 0, BRANCH, 0);
        applyStimulus("j_f", 0, 6'h02, 0, 1, FETCH, 0);
        applyStimulus("j_d", 0, 6'h02, 0, 0, DECODE, 0);
        applyStimulus("j_x", 0, 6'h02, 0, 0, JUMP, 0);

        // fetch with ack delayed 3 cycles
        for (int i = 0; i < 3; i++) applyStimulus("fetch_wait", 0, 6'h02, 0, 0, FETCH, 0);
        applyStimulus("fetch_ack", 0, 6'h02, 0, 1, FETCH, 0);
        applyStimulus("fetch_wait_d", 0, 6'h02, 0, 0, DECODE, 0);
        applyStimulus("fetch_wait_j", 0, 6'h02, 0, 0, JUMP, 0);

        // beq not taken
        applyStimulus("beqnt_f", 0, 6'h04, 0, 1, FETCH, 0);
        applyStimulus("beqnt_d", 0, 6'h04, 0, 0, DECODE, 0);
        applyStimulus("beq_not_taken", 0, 6'h04, 0, 1, BRANCH, 0);

        // illegal opcode halts until reset
        applyStimulus("ill_f", 0, 6'h3F, 0, 1, FETCH, 0);
        applyStimulus("ill_d", 0, 6'h3F, 0, 0, DECODE, 0);
        for (int i = 0; i < 3; i++) applyStimulus("ill_halt", 0, 6'h00, 1, 1, HALT, 0);
        applyStimulus("ill_halt_rst", 1, 6'h00, 0, 0, HALT, 0);
        applyStimulus("ill_reset", 0, 6'h00, 0, 0, RESET, 0);

        // lw with no ack: 16 MEM_RD cycles (count 0..15), then bus-error halt
        applyStimulus("to_f", 0, 6'h23, 0, 1, FETCH, 0);
        applyStimulus("to_d", 0, 6'h23, 0, 0, DECODE, 0);
        applyStimulus("to_a", 0, 6'h23, 0, 0, MEM_ADDR, 0);
        for (int i = 0; i < 16; i++) applyStimulus("to_wait", 0, 6'h23, 0, 0, MEM_RD, 0);
        for (int i = 0; i < 2; i++) applyStimulus("to_halt", 0, 6'h23, 0, 1, HALT, 1);
        applyStimulus("to_halt_rst", 1, 6'h23, 0, 0, HALT, 1);
        applyStimulus("to_reset", 0, 6'h23, 0, 0, RESET, 0);

        // lw with ack in the limit cycle: progresses without error
        applyStimulus("lim_f", 0, 6'h23, 0, 1, FETCH, 0);
        applyStimulus("lim_d", 0, 6'h23, 0, 0, DECODE, 0);
        applyStimulus("lim_a", 0, 6'h23, 0, 0, MEM_ADDR, 0);
        for (int i = 0; i < 15; i++) applyStimulus("lim_wait", 0, 6'h23, 0, 0, MEM_RD, 0);
        applyStimulus("lim_ack", 0, 6'h23, 0, 1, MEM_RD, 0);
        applyStimulus("lim_wb", 0, 6'h23, 0, 0, WB_MEM, 0);

        // reset in the middle of a store
        applyStimulus("rsw_f", 0, 6'h2B, 0, 1, FETCH, 0);
        applyStimulus("rsw_d", 0, 6'h2B, 0, 0, DECODE, 0);
        applyStimulus("rsw_a", 0, 6'h2B, 0, 0, MEM_ADDR, 0);
        applyStimulus("rsw_m", 0, 6'h2B, 0, 0, MEM_WR, 0);
        applyStimulus("rsw_m_rst", 1, 6'h2B, 0, 0, MEM_WR, 0);
        applyStimulus("rsw_reset", 0, 6'h2B, 0, 1, RESET, 0);
        applyStimulus("rsw_refetch", 0, 6'h08, 0, 1, FETCH, 0);
        applyStimulus("rsw_d2", 0, 6'h08, 0, 0, DECODE, 0);
        applyStimulus("rsw_x2", 0, 6'h08, 0, 0, EXEC_I, 0);

        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
